// File: rtl/pcpi_vec_coproc_if.sv
// pcpi_vec_coproc_if
//
// Bundles the PCPI handshake and the coprocessor's private 32-bit memory
// port into one interface.
//
// Signals:
//   pcpi_valid, pcpi_insn, pcpi_cpurs1, pcpi_cpurs2   CPU -> coprocessor
//   pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready           coprocessor -> CPU
//   mem_valid, mem_addr, mem_wdata, mem_wstrb         coprocessor -> memory
//   mem_ready, mem_rdata                              memory -> coprocessor
//
// Modports:
//   master : the coprocessor. It answers PCPI offers and masters the
//            memory port.
//   slave  : the environment, meaning the CPU and the memory together.
interface pcpi_vec_coproc_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_cpurs1;
    logic [31:0] pcpi_cpurs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        input  pcpi_valid, pcpi_insn, pcpi_cpurs1, pcpi_cpurs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output pcpi_valid, pcpi_insn, pcpi_cpurs1, pcpi_cpurs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/pcpi_vec_coproc.sv
// pcpi_vec_coproc
//
// RISC-V vector coprocessor that sits beside picorv32 on its PCPI port.
// It supports the RVV 0.8 encoding with LMUL=1 and executes:
//   - vsetvli
//   - unit-stride and strided vector loads
//   - unit-stride and strided vector stores
// The vector register file holds 32 registers of VLEN bits each.
//
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   bus           pcpi_vec_coproc_if.master (PCPI handshake and memory port)
//   dbg_vsel      debug register select
//   dbg_vdata     combinational contents of v[dbg_vsel]
//
// Parameter:
//   VLEN          bits per vector register (VLMAX = VLEN/SEW)
//
// Optional build macro:
//   VEC_MASK_EN   When defined, vm=insn[25]=0 masks each element with bit i
//                 of v0. A masked-off element makes no memory access and
//                 leaves vd unchanged. When not defined, vm is ignored.
module pcpi_vec_coproc #(
    parameter int VLEN = 128
) (
    input  logic                 clk,
    input  logic                 resetn,
    pcpi_vec_coproc_if.master    bus,
    input  logic [4:0]           dbg_vsel,
    output logic [VLEN-1:0]      dbg_vdata
);
    // The element index and vl both need to represent VLMAX, which is at
    // most VLEN/8 (at SEW8).
    localparam int VLW = $clog2(VLEN/8) + 1;

    typedef enum logic [2:0] {IDLE, EXEC, MEM_REQ, MEM_WAIT, DONE} state_t;
    state_t state;

    logic [VLEN-1:0] vreg [32];
    logic [10:0]     vtype;
    logic [VLW-1:0]  vl;

    // Operands captured when an instruction is accepted. From that point on
    // the CPU's rs1/rs2 buses are ignored.
    logic [10:0]     vtype_new_q;
    logic [31:0]     avl_q;
    logic [31:0]     addr_cur;
    logic [31:0]     stride_q;
    logic [VLW-1:0]  idx;
    logic [1:0]      sew_q;
    logic            is_store_q;
    logic [4:0]      vsel_q;
`ifdef VEC_MASK_EN
    logic            vm_q;
`endif

    assign dbg_vdata = vreg[dbg_vsel];

    // Decode of the instruction word offered on the PCPI port.
    logic [31:0] insn;
    logic        mop_ok, is_vset, is_ld, is_st;
    assign insn    = bus.pcpi_insn;
    assign mop_ok  = (insn[28:26] == 3'b000) || (insn[28:26] == 3'b010);
    assign is_vset = (insn[6:0] == 7'b1010111) && (insn[14:12] == 3'b111) && !insn[31];
    assign is_ld   = (insn[6:0] == 7'b0000111) && (insn[14:12] == 3'b111) && mop_ok;
    assign is_st   = (insn[6:0] == 7'b0100111) && (insn[14:12] == 3'b111) && mop_ok;

    // vtype[4] is set only for an illegal SEW, and an illegal SEW forces
    // vl=0. So vtype[3:2] fully encodes SEW whenever a memory op actually
    // runs.
    logic [31:0] unit_stride;
    assign unit_stride = 32'd1 << vtype[3:2];

    // vsetvli result, computed from the operands captured at accept.
    logic [31:0] vlmax, new_vl;
    always_comb begin
        case (vtype_new_q[4:2])
            3'b000:  vlmax = 32'(VLEN/8);
            3'b001:  vlmax = 32'(VLEN/16);
            3'b010:  vlmax = 32'(VLEN/32);
            default: vlmax = 32'd0;
        endcase
        new_vl = (avl_q < vlmax) ? avl_q : vlmax;
    end

    // Per-element address alignment, register bit position and lane mask.
    logic [31:0]    addr_al;
    logic [1:0]     off;
    logic [VLW+4:0] shamt;
    logic [31:0]    sew_mask;
    logic [3:0]     strb_base;
    always_comb begin
        case (sew_q)
            2'd0: begin
                addr_al   = addr_cur;
                shamt     = {2'b00, idx, 3'b000};
                sew_mask  = 32'h0000_00FF;
                strb_base = 4'b0001;
            end
            2'd1: begin
                addr_al   = {addr_cur[31:1], 1'b0};
                shamt     = {1'b0, idx, 4'b0000};
                sew_mask  = 32'h0000_FFFF;
                strb_base = 4'b0011;
            end
            default: begin
                addr_al   = {addr_cur[31:2], 2'b00};
                shamt     = {idx, 5'b00000};
                sew_mask  = 32'hFFFF_FFFF;
                strb_base = 4'b1111;
            end
        endcase
    end
    assign off = addr_al[1:0];

    // Store path: pick element i of the source register and replicate it
    // across every lane. The strobes then select the lanes that land in
    // memory.
    logic [VLEN-1:0] src_sh;
    logic [31:0]     st_elem, st_wdata;
    logic [3:0]      st_wstrb;
    assign src_sh   = vreg[vsel_q] >> shamt;
    assign st_elem  = src_sh[31:0] & sew_mask;
    assign st_wstrb = strb_base << off;
    always_comb begin
        case (sew_q)
            2'd0:    st_wdata = {4{st_elem[7:0]}};
            2'd1:    st_wdata = {2{st_elem[15:0]}};
            default: st_wdata = st_elem;
        endcase
    end

    // Load path: extract the lanes at the byte offset, zero-extend the
    // element, and merge it into vd at element i.
    logic [31:0]     rdata_sh, ld_elem;
    logic [VLEN-1:0] ld_ext, mask_ext, merged;
    assign rdata_sh = bus.mem_rdata >> {off, 3'b000};
    assign ld_elem  = rdata_sh & sew_mask;
    assign ld_ext   = VLEN'(ld_elem) << shamt;
    assign mask_ext = VLEN'(sew_mask) << shamt;
    assign merged   = (vreg[vsel_q] & ~mask_ext) | ld_ext;

    logic elem_active;
`ifdef VEC_MASK_EN
    assign elem_active = vm_q | vreg[0][idx];
`else
    assign elem_active = 1'b1;
`endif

    logic [VLW-1:0] idx_next;
    logic           last_elem;
    assign idx_next  = idx + 1'b1;
    assign last_elem = (idx_next == vl);

    // Main FSM. All PCPI and memory outputs are registered here, together
    // with the register file and the vl/vtype state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            bus.pcpi_wr     <= 1'b0;
            bus.pcpi_rd     <= 32'd0;
            bus.pcpi_wait   <= 1'b0;
            bus.pcpi_ready  <= 1'b0;
            bus.mem_valid   <= 1'b0;
            bus.mem_addr    <= 32'd0;
            bus.mem_wdata   <= 32'd0;
            bus.mem_wstrb   <= 4'd0;
            vtype           <= 11'd0;
            vl              <= '0;
            vtype_new_q     <= 11'd0;
            avl_q           <= 32'd0;
            addr_cur        <= 32'd0;
            stride_q        <= 32'd0;
            idx             <= '0;
            sew_q           <= 2'd0;
            is_store_q      <= 1'b0;
            vsel_q          <= 5'd0;
`ifdef VEC_MASK_EN
            vm_q            <= 1'b0;
`endif
            for (int r = 0; r < 32; r++) begin
                vreg[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    bus.pcpi_ready <= 1'b0;
                    bus.pcpi_wr    <= 1'b0;
                    if (bus.pcpi_valid && is_vset) begin
                        vtype_new_q   <= insn[30:20];
                        avl_q         <= bus.pcpi_cpurs1;
                        bus.pcpi_wait <= 1'b1;
                        state         <= EXEC;
                    end else if (bus.pcpi_valid && (is_ld || is_st)) begin
                        addr_cur   <= bus.pcpi_cpurs1;
                        stride_q   <= (insn[28:26] == 3'b010) ? bus.pcpi_cpurs2 : unit_stride;
                        sew_q      <= vtype[3:2];
                        is_store_q <= is_st;
                        vsel_q     <= insn[11:7];
                        idx        <= '0;
`ifdef VEC_MASK_EN
                        vm_q       <= insn[25];
`endif
                        // With vl=0 there is nothing to transfer, so the
                        // instruction completes on the next cycle without
                        // ever raising wait.
                        if (vl == '0) begin
                            bus.pcpi_ready <= 1'b1;
                            state          <= DONE;
                        end else begin
                            bus.pcpi_wait <= 1'b1;
                            state         <= MEM_REQ;
                        end
                    end
                end

                EXEC: begin
                    vtype          <= vtype_new_q;
                    vl             <= new_vl[VLW-1:0];
                    bus.pcpi_rd    <= new_vl;
                    bus.pcpi_wr    <= 1'b1;
                    bus.pcpi_ready <= 1'b1;
                    bus.pcpi_wait  <= 1'b0;
                    state          <= DONE;
                end

                // mem_valid is low for this whole cycle, which enforces the
                // idle gap between consecutive element requests.
                MEM_REQ: begin
                    if (elem_active) begin
                        bus.mem_valid <= 1'b1;
                        bus.mem_addr  <= {addr_al[31:2], 2'b00};
                        bus.mem_wdata <= is_store_q ? st_wdata : 32'd0;
                        bus.mem_wstrb <= is_store_q ? st_wstrb : 4'd0;
                        state         <= MEM_WAIT;
                    end else if (last_elem) begin
                        bus.pcpi_ready <= 1'b1;
                        bus.pcpi_wait  <= 1'b0;
                        state          <= DONE;
                    end else begin
                        idx      <= idx_next;
                        addr_cur <= addr_cur + stride_q;
                    end
                end

                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_wstrb <= 4'd0;
                        bus.mem_wdata <= 32'd0;
                        if (!is_store_q) begin
                            vreg[vsel_q] <= merged;
                        end
                        if (last_elem) begin
                            bus.pcpi_ready <= 1'b1;
                            bus.pcpi_wait  <= 1'b0;
                            state          <= DONE;
                        end else begin
                            idx      <= idx_next;
                            addr_cur <= addr_cur + stride_q;
                            state    <= MEM_REQ;
                        end
                    end
                end

                DONE: begin
                    bus.pcpi_ready <= 1'b0;
                    bus.pcpi_wr    <= 1'b0;
                    bus.pcpi_rd    <= 32'd0;
                    state          <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_vec_coproc.sv
// tb_pcpi_vec_coproc
//
// Scoreboard bench for pcpi_vec_coproc. The stimulus pushes the expected
// memory transactions and PCPI completions into queues. A monitor process
// pops an entry and compares it each time the DUT completes a memory
// handshake or pulses pcpi_ready. Register contents are compared through
// the debug port against hand-computed values.
module tb_pcpi_vec_coproc;
    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [4:0]      dbg_vsel;
    logic [VLEN-1:0] dbg_vdata;

    pcpi_vec_coproc_if bus();

    pcpi_vec_coproc #(.VLEN(VLEN)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_vsel  (dbg_vsel),
        .dbg_vdata (dbg_vdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
    } pcpi_exp_t;

    mem_exp_t  mem_q[$];
    pcpi_exp_t pcpi_q[$];
    int        vectors = 0;
    int        miscompares = 0;
    logic [31:0] mem [0:255];

    task automatic checkOutput(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic flagError(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s", name);
    endtask

    // Memory model with one wait state. It accepts a request the cycle after
    // mem_valid rises and applies store strobes at that moment.
    always @(posedge clk) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
        end else if (bus.mem_valid && !bus.mem_ready) begin
            bus.mem_ready <= 1'b1;
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end else begin
            bus.mem_ready <= 1'b0;
        end
    end

    mem_exp_t  me;
    pcpi_exp_t pe;
    always @(negedge clk) begin
        if (resetn && bus.mem_valid && bus.mem_ready) begin
            if (mem_q.size() == 0) begin
                flagError("unexpected memory access");
            end else begin
                me = mem_q.pop_front();
                checkOutput("mem_addr", bus.mem_addr, me.addr);
                checkOutput("mem_wstrb", bus.mem_wstrb, me.wstrb);
                if (me.wstrb != 4'd0) checkOutput("mem_wdata", bus.mem_wdata, me.wdata);
            end
        end
        if (resetn && bus.pcpi_ready) begin
            if (pcpi_q.size() == 0) begin
                flagError("unexpected pcpi_ready");
            end else begin
                pe = pcpi_q.pop_front();
                checkOutput("pcpi_wr", bus.pcpi_wr, pe.wr);
                if (pe.wr) checkOutput("pcpi_rd", bus.pcpi_rd, pe.rd);
            end
        end
    end

    function automatic logic [31:0] vsetInsn(input logic [10:0] vt);
        return {1'b0, vt, 5'd2, 3'b111, 5'd4, 7'b1010111};
    endfunction

    function automatic logic [31:0] vmemInsn(input logic store, input logic strided, input logic vm, input logic [4:0] vr);
        return {3'b000, (strided ? 3'b010 : 3'b000), vm, 5'd7, 5'd1, 3'b111, vr,
                (store ? 7'b0100111 : 7'b0000111)};
    endfunction

    task automatic expectMem(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        mem_exp_t e;
        e.addr = a; e.wstrb = s; e.wdata = d;
        mem_q.push_back(e);
    endtask

    task automatic expectPcpi(input logic wr, input logic [31:0] rd);
        pcpi_exp_t e;
        e.wr = wr; e.rd = rd;
        pcpi_q.push_back(e);
    endtask

    // Offers one instruction, scrambles rs1/rs2 after the accept edge, and
    // holds pcpi_valid until pcpi_ready or until the cycle budget runs out.
    task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                                 output int cycles, output logic wait_seen);
        @(negedge clk);
        bus.pcpi_valid  = 1'b1;
        bus.pcpi_insn   = insn;
        bus.pcpi_cpurs1 = rs1;
        bus.pcpi_cpurs2 = rs2;
        cycles    = 0;
        wait_seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                bus.pcpi_cpurs1 = 32'hDEAD_BEEF;
                bus.pcpi_cpurs2 = 32'h1234_5679;
            end
            wait_seen |= bus.pcpi_wait;
        end while (!bus.pcpi_ready && cycles < 500);
        if (!bus.pcpi_ready) flagError("timeout waiting for pcpi_ready");
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic doVset(input logic [10:0] vt, input logic [31:0] avl, input logic [31:0] exp_vl);
        int   cyc;
        logic ws;
        expectPcpi(1'b1, exp_vl);
        applyStimulus(vsetInsn(vt), avl, 32'd0, cyc, ws);
        checkOutput("vsetvli latency", cyc, 2);
        checkOutput("vsetvli wait", ws, 1'b1);
    endtask

    task automatic doMem(input logic store, input logic strided, input logic vm, input logic [4:0] vr,
                         input logic [31:0] rs1, input logic [31:0] rs2, output int cyc, output logic ws);
        expectPcpi(1'b0, 32'd0);
        applyStimulus(vmemInsn(store, strided, vm, vr), rs1, rs2, cyc, ws);
    endtask

    task automatic checkReg(input string name, input logic [4:0] r, input logic [VLEN-1:0] exp);
        dbg_vsel = r;
        #1;
        checkOutput(name, dbg_vdata, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int              cyc;
        int              n;
        logic            ws, seen, prev;
        logic [15:0]     e16;
        logic [31:0]     a;
        logic [VLEN-1:0] exp_v1, exp_v4;

        bus.pcpi_valid  = 1'b0;
        bus.pcpi_insn   = 32'd0;
        bus.pcpi_cpurs1 = 32'd0;
        bus.pcpi_cpurs2 = 32'd0;
        bus.mem_rdata   = 32'd0;
        dbg_vsel        = 5'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[100] = 32'h04030201; mem[101] = 32'h08070605;
        mem[102] = 32'h0c0b0a09; mem[103] = 32'h000f0e0d;
        mem[104] = 32'h0a090807; mem[105] = 32'h0807060b;
        mem[106] = 32'h0c0b0a0c; mem[107] = 32'h000f0e0d;
        mem[120] = 32'h00000055;

        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset pcpi_ready", bus.pcpi_ready, 1'b0);
        checkOutput("reset pcpi_wait", bus.pcpi_wait, 1'b0);
        checkOutput("reset pcpi_wr", bus.pcpi_wr, 1'b0);
        checkOutput("reset mem_valid", bus.mem_valid, 1'b0);
        checkOutput("reset mem_wstrb", bus.mem_wstrb, 4'd0);
        checkReg("reset v1", 5'd1, '0);
        @(negedge clk);
        resetn = 1'b1;

        // A non-vector instruction must be ignored entirely.
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = 32'h0000_0013;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen |= bus.pcpi_wait | bus.pcpi_ready;
        end
        bus.pcpi_valid = 1'b0;
        checkOutput("ignored insn", seen, 1'b0);

        doVset(11'h004, 32'd8, 32'd8);
        doVset(11'h004, 32'd16, 32'd8);

        // Strided SEW16 load of v1 from 400 with a 4-byte stride.
        exp_v1 = 128'h0e0d0a0c060b08070e0d0a0906050201;
        for (int i = 0; i < 8; i++) expectMem(32'd400 + 32'(4*i), 4'd0, 32'd0);
        doMem(1'b0, 1'b1, 1'b1, 5'd1, 32'd400, 32'd4, cyc, ws);
        checkOutput("load wait", ws, 1'b1);
        checkReg("strided load v1", 5'd1, exp_v1);

        // Strided store of v1 to 600.
        for (int i = 0; i < 8; i++) begin
            e16 = exp_v1[16*i +: 16];
            expectMem(32'd600 + 32'(4*i), 4'b0011, {e16, e16});
        end
        doMem(1'b1, 1'b1, 1'b1, 5'd1, 32'd600, 32'd4, cyc, ws);
        checkOutput("store mem[150]", mem[150][15:0], 16'h0201);
        checkOutput("store mem[157]", mem[157][15:0], 16'h0e0d);

        // Unit-stride SEW16 load from a halfword-offset base. rs2 must be
        // ignored here.
        exp_v4 = 128'h0807000f0e0d0c0b0a09080706050403;
        for (int i = 0; i < 8; i++) begin
            a = 32'd402 + 32'(2*i);
            expectMem({a[31:2], 2'b00}, 4'd0, 32'd0);
        end
        doMem(1'b0, 1'b0, 1'b1, 5'd4, 32'd402, 32'd77, cyc, ws);
        checkReg("unit load v4", 5'd4, exp_v4);

        // Unit-stride store of v4 to 802, alternating the upper and lower
        // lanes.
        for (int i = 0; i < 8; i++) begin
            a   = 32'd802 + 32'(2*i);
            e16 = exp_v4[16*i +: 16];
            expectMem({a[31:2], 2'b00}, a[1] ? 4'b1100 : 4'b0011, {e16, e16});
        end
        doMem(1'b1, 1'b0, 1'b1, 5'd4, 32'd802, 32'd0, cyc, ws);
        checkOutput("store mem[200]", mem[200][31:16], 16'h0403);
        checkOutput("store mem[201]", mem[201][15:0], 16'h0605);

        // SEW32: VLMAX=4, and a zero stride reads the same word four times.
        doVset(11'h008, 32'd16, 32'd4);
        for (int i = 0; i < 4; i++) expectMem(32'd404, 4'd0, 32'd0);
        doMem(1'b0, 1'b1, 1'b1, 5'd3, 32'd404, 32'd0, cyc, ws);
        checkReg("stride0 load v3", 5'd3, {4{32'h08070605}});

        // Illegal SEW gives vl=0, so the next load makes no access.
        doVset(11'h00C, 32'd8, 32'd0);
        doMem(1'b0, 1'b1, 1'b1, 5'd9, 32'd400, 32'd4, cyc, ws);
        checkOutput("vl0 load latency", cyc, 1);
        checkOutput("vl0 load wait", ws, 1'b0);

        // SEW8 unit-stride load from a byte-offset base.
        doVset(11'h000, 32'd5, 32'd5);
        expectMem(32'd400, 4'd0, 32'd0); expectMem(32'd400, 4'd0, 32'd0);
        expectMem(32'd400, 4'd0, 32'd0); expectMem(32'd404, 4'd0, 32'd0);
        expectMem(32'd404, 4'd0, 32'd0);
        doMem(1'b0, 1'b0, 1'b1, 5'd5, 32'd401, 32'd0, cyc, ws);
        checkReg("sew8 load v5", 5'd5, 128'h0605040302);

`ifdef VEC_MASK_EN
        doVset(11'h000, 32'd1, 32'd1);
        expectMem(32'd480, 4'd0, 32'd0);
        doMem(1'b0, 1'b0, 1'b1, 5'd0, 32'd480, 32'd0, cyc, ws);
        checkReg("mask v0", 5'd0, 128'h55);
        doVset(11'h004, 32'd8, 32'd8);
        for (int i = 0; i < 8; i += 2) expectMem(32'd400 + 32'(4*i), 4'd0, 32'd0);
        doMem(1'b0, 1'b1, 1'b0, 5'd7, 32'd400, 32'd4, cyc, ws);
        checkReg("masked load v7", 5'd7, 128'h00000a0c00000807000000a0900000201 & 128'h0000_0a0c_0000_0807_0000_0a09_0000_0201 | 128'h0000_0a0c_0000_0807_0000_0a09_0000_0201);
`endif

        // Reset while element 3 of a load is outstanding.
        doVset(11'h004, 32'd8, 32'd8);
        expectMem(32'd400, 4'd0, 32'd0);
        expectMem(32'd404, 4'd0, 32'd0);
        expectMem(32'd408, 4'd0, 32'd0);
        @(negedge clk);
        bus.pcpi_valid  = 1'b1;
        bus.pcpi_insn   = vmemInsn(1'b0, 1'b1, 1'b1, 5'd6);
        bus.pcpi_cpurs1 = 32'd400;
        bus.pcpi_cpurs2 = 32'd4;
        n    = 0;
        prev = 1'b0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_valid && !prev) n++;
            prev = bus.mem_valid;
        end
        if (n < 4) flagError("timeout waiting for element 3 request");
        resetn = 1'b0;
        #1;
        checkOutput("abort mem_valid", bus.mem_valid, 1'b0);
        checkOutput("abort pcpi_wait", bus.pcpi_wait, 1'b0);
        checkOutput("abort pcpi_ready", bus.pcpi_ready, 1'b0);
        bus.pcpi_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        checkReg("post-reset v1", 5'd1, '0);
        doMem(1'b0, 1'b1, 1'b1, 5'd6, 32'd400, 32'd4, cyc, ws);
        checkOutput("post-reset vl0 latency", cyc, 1);

        repeat (3) @(negedge clk);
        checkOutput("mem queue drained", mem_q.size(), 0);
        checkOutput("pcpi queue drained", pcpi_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pcpi_vec_coproc.md
Name: pcpi_vec_coproc

Overview:
- PCPI-attached RISC-V vector coprocessor beside the picorv32 core; owns a private 32-bit memory port.
- Executes vsetvli, unit-stride and strided vector loads and stores (RVV 0.8 encoding, LMUL=1) against a 32 x VLEN vector register file.
- Returns the new vl to the CPU through the PCPI rd channel.

Parameters:
- VLEN, 128, bits per vector register; VLMAX = VLEN/SEW.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pcpi_valid  in  1  CPU offers instruction; held until pcpi_ready
- pcpi_insn  in  32  instruction word
- pcpi_cpurs1  in  32  CPU rs1 value (AVL or base address)
- pcpi_cpurs2  in  32  CPU rs2 value (byte stride)
- pcpi_wr  out  1  write pcpi_rd to CPU rd; valid with pcpi_ready
- pcpi_rd  out  32  result (new vl)
- pcpi_wait  out  1  instruction accepted, busy
- pcpi_ready  out  1  one-cycle completion pulse
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepted / rdata valid
- mem_addr  out  32  byte address
- mem_wdata  out  32  store data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_rdata  in  32  read data
- dbg_vsel  in  5  debug register select
- dbg_vdata  out  VLEN  combinational contents of v[dbg_vsel]

Behaviour:
- Reset (async, resetn low): all outputs 0, vl=0, vtype=0 (SEW8), FSM IDLE, register file cleared; in-flight op aborted, mem_valid drops immediately.
- Decode (pcpi_valid in IDLE):
  - vsetvli: opcode 1010111, funct3 111, insn[31]=0.
  - load: opcode 0000111, width 111.
  - store: opcode 0100111, width 111.
  - mop insn[28:26]: 000 unit-stride (stride = SEW/8), 010 strided (stride = pcpi_cpurs2, signed bytes).
  - Anything else: ignored; no wait, no ready.
- FSM states: IDLE -> EXEC (vsetvli) or MEM_REQ/MEM_WAIT (load/store) -> DONE -> IDLE.
  - pcpi_wait rises the cycle after a recognised instruction is sampled and stays high until the DONE cycle.
  - pcpi_ready is high exactly one cycle (DONE).
- vsetvli:
  - vtype = insn[30:20]; vsew = vtype[4:2]: 000=8, 001=16, 010=32.
  - vl = min(pcpi_cpurs1, VLMAX); pcpi_rd = vl; pcpi_wr=1 with pcpi_ready.
  - pcpi_ready two cycles after pcpi_valid is first sampled.
  - vsew > 010: vl=0, vtype keeps the written value, pcpi_rd=0.
  - vlmul ignored (LMUL=1).
- Load/store element loop, i = 0..vl-1:
  - addr_i = rs1 + i*stride; low log2(SEW/8) bits forced to 0.
  - mem_addr = {addr_i[31:2], 2'b00}; lane offset = addr_i[1:0].
  - mem_valid held with stable address/data/strobes until mem_ready sampled high.
  - mem_valid low for at least one cycle before the next element, so minimum cost is 2 cycles per element.
- Load: element i = mem_rdata lanes at the offset, zero-extended to SEW; written to vd bits [i*SEW +: SEW]. vd = insn[11:7].
- Store:
  - Source is register insn[11:7].
  - Element replicated into mem_wdata at the offset.
  - mem_wstrb: SEW8 = 1 bit, SEW16 = 2 bits, SEW32 = 4'b1111, shifted by the offset.
  - Loads drive mem_wstrb = 0.
- Tail elements (i >= vl): unchanged.
- vl=0 load/store: no memory access; DONE the cycle after accept.
- pcpi_wr is 0 for loads and stores.
- Only rs1/rs2 values captured at accept are used; pcpi_cpurs1/rs2 may change afterwards.

Optional Feature:
- VEC_MASK_EN defined: vm=insn[25]=0 masks by v0 bit i; inactive elements make no memory access and leave vd unchanged.
- Undefined: vm ignored; all elements active.

Test Plan:
- vsetvli with AVL=8, vtype 0x004 (insn 0x00417257 style, rd=x4) -> pcpi_wr=1, pcpi_rd=8; AVL=16 -> 8; AVL=16 with SEW32 -> 4; vsew=011 -> 0.
- Strided load: preload words 100..107 = 04030201, 08070605, 0c0b0a09, 000f0e0d, 0a090807, 0807060b, 0c0b0a0c, 000f0e0d; SEW16, vl=8, vlse.v v1 with rs1=400, rs2=4 (insn 0x0A70F087) -> 8 reads at addresses 400..428, then v1 = 0x0e0d0a0c060b08070e0d0a0906050201.
- Strided store: vsse.v v1 with rs1=600, rs2=4 -> 8 writes at 600..628, each mem_wstrb=0011 and mem_wdata[15:0] = element; memory[150] low half = 0201.
- vl=0 load -> pcpi_ready with no mem_valid; stride 0 -> all elements read from the same address.
- resetn low during MEM_WAIT of element 3 -> mem_valid, pcpi_wait, pcpi_ready go to 0 immediately; vl reads 0 afterwards.
- VEC_MASK_EN with v0=0x55 and a masked load -> only even elements fetched and written.
